// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin scheduler sharing one UART TX line between
// two byte requesters. Frames (start, data LSB first, optional parity, one or
// two stop bits) advance on baud_tick; configuration is captured per frame.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   baud_tick           one-cycle pulse per bit period
//   cfg_parity_en       insert parity bit after data
//   cfg_parity_odd      1 = odd parity, 0 = even
//   cfg_stop2           1 = two stop bits, 0 = one
//   reqN_valid/data     requester N byte offer
//   reqN_ready          combinational accept strobe for requester N
//   tx                  registered serial line, idle high
//   busy                frame accepted and not yet complete
//   done / done_src     one-cycle completion pulse and its requester index
module uart_tx_scheduler #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 done_src
);

  localparam int unsigned BUF_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               src_q, src_d;
  logic               par_en_q, par_en_d;
  logic               par_odd_q, par_odd_d;
  logic               stop2_q, stop2_d;
  logic [BUF_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               tx_d, busy_d, done_d, done_src_d;
  logic               grant;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      src_q      <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_src   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      src_q      <= src_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx         <= tx_d;
      busy       <= busy_d;
      done       <= done_d;
      done_src   <= done_src_d;
    end
  end

  // Arbitration, frame sequencing and next line level
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    src_d      = src_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    done_src_d = done_src;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    tx_d       = 1'b1;

    // Contention goes to the requester not served last; a lone valid wins
    grant = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    case (state_q)
      S_IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          req0_ready = ~grant;
          req1_ready = grant;
          last_d     = grant;
          src_d      = grant;
          data_d     = grant ? BUF_W'(req1_data) : BUF_W'(req0_data);
          par_en_d   = cfg_parity_en;
          par_odd_d  = cfg_parity_odd;
          stop2_d    = cfg_stop2;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (baud_tick) state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            done_src_d = src_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the tick edge
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_cnt_d];
      S_PARITY: tx_d = (^data_q) ^ par_odd_q;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin transmit scheduler that shares one UART TX line between two byte requesters and sequences each frame on the `baud_tick` pulse from the UART baud rate generator. It sits between the APB-side TX sources and the serial pin. It owns arbitration, frame sequencing (start, data, optional parity, one or two stop bits) and per-frame configuration capture.

## Interface
Parameters:
- `DATA_BITS`, default 8: payload bits per frame, LSB first; legal range 5..8.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `baud_tick`, input, 1: one-cycle pulse per bit period, from the baud rate generator.
- `cfg_parity_en`, input, 1: insert a parity bit after the data bits.
- `cfg_parity_odd`, input, 1: 1 selects odd parity, 0 selects even.
- `cfg_stop2`, input, 1: 1 selects two stop bits, 0 selects one.
- `req0_valid`, input, 1: requester 0 has a byte to send.
- `req0_data`, input, DATA_BITS: requester 0 byte.
- `req0_ready`, output, 1: requester 0 byte accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `tx`, output, 1: serial line, registered, idle high.
- `busy`, output, 1: a frame is accepted and not yet complete.
- `done`, output, 1: one-cycle pulse when a frame's last stop bit ends.
- `done_src`, output, 1: requester index of the frame completing; valid only with `done`.

## Operation
- States are IDLE, ALIGN, START, DATA, PARITY, STOP.
- Acceptance happens only in IDLE. `reqN_ready` is combinational: `state==IDLE && grant==N && reqN_valid`. At most one ready is high per cycle.
- Arbitration: `last` is a 1-bit register, reset to 1.
  - One valid: grant it.
  - Both valid: grant `~last`.
  - On acceptance, `last` takes the granted index.
  - Requester 0 therefore wins the first contention after reset.
- On acceptance, capture data, the source index, `cfg_parity_en`, `cfg_parity_odd` and `cfg_stop2`, then go to ALIGN. Config changes mid-frame have no effect on that frame.
- State transitions advance only on cycles with `baud_tick`=1:
  - ALIGN to START.
  - START to DATA.
  - DATA shifts out LSB first. After DATA_BITS ticks it goes to PARITY if enabled, otherwise STOP.
  - PARITY to STOP.
  - STOP ends after 1 tick, or 2 ticks when `stop2` was captured, then returns to IDLE.
- Line level per state:
  - IDLE and ALIGN: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=current data bit.
  - PARITY: even gives XOR of the data bits; odd gives the inverse of that XOR.
  - STOP: `tx`=1.
- Counters: a 3-bit data-bit counter and a 1-bit stop counter, both cleared on entering their state.
- `busy` is 1 in every state except IDLE.
- `baud_tick` in IDLE is ignored.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `done`=0, `done_src`=0.
  - Both readies are 0 only while `rst_n`=0.
  - State IDLE, `last`=1.
- Reset mid-frame: `tx` goes to 1 asynchronously and the frame is dropped. No `done` is issued.
- `tx` and `busy` are registered; they change the cycle after the deciding edge.
  - Acceptance at edge E gives `busy`=1 from E+1.
  - A `baud_tick` seen in state S updates `tx` on the following edge.
- Each bit therefore lasts exactly one tick-to-tick period. The start bit is aligned to the first tick after acceptance, never to the acceptance cycle.
- `done` is asserted in the cycle after the final stop tick, together with the return to IDLE and `busy`=0. A new request can be accepted in that same cycle.
- Back-to-back frames have exactly one extra idle bit period between the last stop bit and the next start bit, caused by the ALIGN wait.
- Frame length in bit periods: 1 + DATA_BITS + parity_en + (1 or 2).

## Test plan
- Single byte: req0 sends 0xA5 with no parity and one stop bit. Sampled per tick, `tx` must be 0,1,0,1,0,0,1,0,1,1, then `done`=1 with `done_src`=0 and `busy`=0.
- Parity: send 0x07 with even parity, then odd parity. The parity bit must be 1 for even and 0 for odd. Repeat with two stop bits; the stop phase must last 2 ticks.
- Contention: both requesters hold valid continuously from reset. Grants must alternate 0,1,0,1, each frame's `done_src` must match, and there must be exactly one idle bit between frames.
- Config capture: toggle `cfg_parity_en` and `cfg_stop2` during a frame. The in-flight frame must keep its captured settings and the next frame must use the new ones.
- Alignment: accept a byte 3 cycles before a tick. `tx` must go low the cycle after that tick, not earlier. Ticks seen in IDLE must cause no `tx` activity.
- Reset mid-DATA: assert `rst_n`=0. `tx` must be 1 immediately, `busy`=0, and there must be no `done`. After release, a both-valid request must be granted to requester 0.
